// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared CPU types plus the multiply/divide unit's state and constants.
package mips_cpu_pkg;

  localparam int WIDTH_REG = 32;

  typedef logic [WIDTH_REG-1:0]   word_t;
  typedef logic [2*WIDTH_REG-1:0] double_word_t;

  typedef enum logic {ALU_MULT, ALU_DIV} mult_op_enum;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} mdu_state_enum;

  localparam int    MDU_ITERS      = 32;
  localparam word_t DIV_BY_ZERO_LO = 32'hFFFFFFFF;

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - restoring divider datapath, one quotient bit per step on unsigned magnitudes.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_sub;
  logic             w_fits;

  // The quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_fits    = w_shifted >= {1'b0, r_divisor};
  assign w_sub     = w_shifted[WIDTH-1:0] - r_divisor;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_rem     <= '0;
      r_quo     <= i_dividend;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      r_rem <= w_fits ? w_sub : w_shifted[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/DIV unit with HI/LO; MDU_FAST_MULT_EN selects a one-cycle multiply.
module mult_div_unit
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_REG
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  mult_op_enum      i_op,
  input  logic             i_sign,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic             i_cancel,
  input  logic             i_we_hi,
  input  logic             i_we_lo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(MDU_ITERS);

  mdu_state_enum      r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_op_div, r_neg_a, r_neg_b, r_divz, r_done;

  logic               w_neg_a, w_neg_b, w_accept, w_last;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo, w_rem, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_neg_a  = i_sign & i_src_a[WIDTH-1];
  assign w_neg_b  = i_sign & i_src_b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -i_src_a : i_src_a;
  assign w_abs_b  = w_neg_b ? -i_src_b : i_src_b;
  assign w_accept = (r_state == IDLE) && i_start && !i_cancel;
  assign w_last   = r_cnt == CNT_W'(MDU_ITERS - 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (i_op != ALU_DIV)   w_next = MUL;
          else if (i_src_b == '0) w_next = FINISH;
          else                   w_next = DIV;
        end
      end
`ifdef MDU_FAST_MULT_EN
      MUL:    w_next = FINISH;
`else
      MUL:    if (w_last) w_next = FINISH;
`endif
      DIV:    if (w_last) w_next = FINISH;
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_cancel && (r_state != IDLE)) w_next = IDLE;
  end

`ifndef MDU_FAST_MULT_EN
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_op_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_divz   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= (r_state == FINISH) && !i_cancel;
      if (w_accept) begin
        r_cnt    <= '0;
        r_mcand  <= w_abs_a;
        r_prod   <= {{WIDTH{1'b0}}, w_abs_b};
        r_op_div <= i_op == ALU_DIV;
        r_neg_a  <= w_neg_a;
        r_neg_b  <= w_neg_b;
        r_divz   <= i_src_b == '0;
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt + 1'b1;
`ifdef MDU_FAST_MULT_EN
        r_prod <= {{WIDTH{1'b0}}, r_mcand} * {{WIDTH{1'b0}}, r_prod[WIDTH-1:0]};
`else
        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
`endif
      end else if (r_state == DIV) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // MT writes only land while idle and lose to a start in the same cycle.
      if ((r_state == FINISH) && !i_cancel) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if ((r_state == IDLE) && !i_start) begin
        if (i_we_hi) r_hi <= i_wdata;
        if (i_we_lo) r_lo <= i_wdata;
      end
    end
  end

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_accept),
    .i_step      (r_state == DIV),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? -r_prod : r_prod;

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_op_div) begin
      if (r_divz) begin
        // Rebuild the raw dividend from its latched magnitude and sign.
        w_res_hi = r_neg_a ? -r_mcand : r_mcand;
        w_res_lo = WIDTH'(DIV_BY_ZERO_LO);
      end else begin
        w_res_hi = r_neg_a ? -w_rem : w_rem;
        w_res_lo = (r_neg_a ^ r_neg_b) ? -w_quo : w_quo;
      end
    end
  end

  assign o_busy = r_state != IDLE;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  import mips_cpu_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT  = 34;
  localparam int DIVZ_LAT = 2;
  localparam int MAX_WAIT = 100;

  logic        clk = 1'b0;
  logic        rst, start, sign, cancel, we_hi, we_lo;
  mult_op_enum op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] g_hi, g_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_sign(sign),
    .i_src_a(src_a), .i_src_b(src_b), .i_cancel(cancel),
    .i_we_hi(we_hi), .i_we_lo(we_lo), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic is_div, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!is_div) begin
      res = 64'(sa * sb);
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFFFFFF};
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  function automatic int model_lat(input logic is_div, input logic [31:0] b);
    if (!is_div) return MUL_LAT;
    if (b == 32'd0) return DIVZ_LAT;
    return DIV_LAT;
  endfunction

  // Called at a negedge; drives the request in the current cycle and returns at the negedge of the done cycle.
  task automatic run_op(input logic is_div, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output logic busy_c1);
    start = 1'b1; op = is_div ? ALU_DIV : ALU_MULT; sign = sgn; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    busy_c1 = busy;
    lat = 1;
    while (done !== 1'b1 && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    res = {hi, lo};
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = ALU_MULT; sign = 1'b0; src_a = '0; src_b = '0;
    cancel = 1'b0; we_hi = 1'b0; we_lo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b want 00", {busy, done}); end
    tests_run++;
    if ({hi, lo} !== 64'd0) begin tests_failed++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
    g_hi = '0; g_lo = '0;
  endtask

  task automatic test_directed;
    logic        d_div[6], d_sgn[6];
    logic [31:0] d_a[6], d_b[6];
    logic [63:0] d_exp[6];
    int          d_lat[6];
    logic [63:0] res;
    int          lat;
    logic        b1;
    d_div = '{0, 0, 1, 1, 1, 1};
    d_sgn = '{0, 1, 1, 0, 1, 0};
    d_a   = '{32'hFFFFFFFF, -32'sd3, -32'sd7, 32'd7, 32'h80000000, 32'h1234};
    d_b   = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
    d_exp = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFF_FFFFFFFD,
              64'h00000001_00000003, 64'h00000000_80000000, 64'h00001234_FFFFFFFF};
    d_lat = '{MUL_LAT, MUL_LAT, DIV_LAT, DIV_LAT, DIV_LAT, DIVZ_LAT};
    for (int i = 0; i < 6; i++) begin
      run_op(d_div[i], d_sgn[i], d_a[i], d_b[i], res, lat, b1);
      tests_run++;
      if (res !== d_exp[i]) begin tests_failed++; $display("FAIL directed_%0d_hilo: got %h want %h", i, res, d_exp[i]); end
      tests_run++;
      if (lat !== d_lat[i]) begin tests_failed++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, d_lat[i]); end
      tests_run++;
      if ({b1, busy} !== 2'b10) begin tests_failed++; $display("FAIL directed_%0d_busy: got %b want 10", i, {b1, busy}); end
      g_hi = d_exp[i][63:32]; g_lo = d_exp[i][31:0];
    end
  endtask

  task automatic test_random;
    logic        is_div, sgn, b1;
    logic [31:0] a, b;
    logic [63:0] res, exp;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      is_div = 1'($urandom_range(0, 1));
      sgn    = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($signed($urandom_range(0, 40)) - 20); b = 32'($signed($urandom_range(0, 10)) - 5); end
        default: ;
      endcase
      exp = model(is_div, sgn, a, b);
      run_op(is_div, sgn, a, b, res, lat, b1);
      tests_run++;
      if (res !== exp) begin tests_failed++; $display("FAIL random_%0d_hilo (div=%0d sgn=%0d a=%h b=%h): got %h want %h", i, is_div, sgn, a, b, res, exp); end
      tests_run++;
      if (lat !== model_lat(is_div, b)) begin tests_failed++; $display("FAIL random_%0d_latency: got %0d want %0d", i, lat, model_lat(is_div, b)); end
      g_hi = exp[63:32]; g_lo = exp[31:0];
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a0, b0, a1, b1v;
    logic [63:0] res, exp;
    int          lat;
    logic        bc;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1v = $urandom | 32'd1;
    run_op(1'b0, 1'b1, a0, b0, res, lat, bc);
    exp = model(1'b0, 1'b1, a0, b0);
    tests_run++;
    if (res !== exp) begin tests_failed++; $display("FAIL b2b_first_hilo: got %h want %h", res, exp); end
    run_op(1'b1, 1'b1, a1, b1v, res, lat, bc);
    exp = model(1'b1, 1'b1, a1, b1v);
    tests_run++;
    if (res !== exp) begin tests_failed++; $display("FAIL b2b_second_hilo: got %h want %h", res, exp); end
    tests_run++;
    if (lat !== DIV_LAT) begin tests_failed++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, DIV_LAT); end
    g_hi = exp[63:32]; g_lo = exp[31:0];
  endtask

  task automatic test_cancel;
    logic busy_ok, saw_done;
    busy_ok = 1'b1; saw_done = 1'b0;
    start = 1'b1; op = ALU_DIV; sign = 1'b0; src_a = $urandom; src_b = $urandom | 32'd1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) saw_done = 1'b1;
      if (c == 5) begin start = 1'b1; op = ALU_MULT; src_a = 32'd9; src_b = 32'd9; end
      if (c == 6) start = 1'b0;
      if (c == 10) cancel = 1'b1;
    end
    tests_run++;
    if (busy_ok !== 1'b1) begin tests_failed++; $display("FAIL cancel_busy_before: got %b want 1", busy_ok); end
    @(negedge clk);
    cancel = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL cancel_busy_after: got %b want 0", busy); end
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL cancel_no_done: got %b want 0", saw_done); end
    tests_run++;
    if ({hi, lo} !== {g_hi, g_lo}) begin tests_failed++; $display("FAIL cancel_hilo_kept: got %h want %h", {hi, lo}, {g_hi, g_lo}); end
  endtask

  task automatic test_mt;
    logic [63:0] exp;
    logic [31:0] a, b;
    int          n;
    we_hi = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    we_hi = 1'b0;
    tests_run++;
    if (hi !== 32'h12345678) begin tests_failed++; $display("FAIL mthi_idle: got %h want 12345678", hi); end
    g_hi = 32'h12345678;
    we_lo = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    we_lo = 1'b0;
    tests_run++;
    if ({hi, lo} !== {g_hi, 32'hA5A5_0F0F}) begin tests_failed++; $display("FAIL mtlo_idle: got %h want %h", {hi, lo}, {g_hi, 32'hA5A5_0F0F}); end
    g_lo = 32'hA5A5_0F0F;
    a = $urandom; b = $urandom;
    exp = model(1'b0, 1'b0, a, b);
    start = 1'b1; op = ALU_MULT; sign = 1'b0; src_a = a; src_b = b;
    n = 0;
    while (done !== 1'b1 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (n == 2) begin we_lo = 1'b1; wdata = 32'hCAFE; end
      if (n == 3) we_lo = 1'b0;
    end
    tests_run++;
    if ({hi, lo} !== exp) begin tests_failed++; $display("FAIL mtlo_busy_dropped: got %h want %h", {hi, lo}, exp); end
    g_hi = exp[63:32]; g_lo = exp[31:0];
    start = 1'b1; op = ALU_DIV; sign = 1'b0; src_a = 32'h1234; src_b = 32'd0;
    we_hi = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; we_hi = 1'b0;
    tests_run++;
    if (hi !== g_hi) begin tests_failed++; $display("FAIL mthi_with_start_dropped: got %h want %h", hi, g_hi); end
    @(negedge clk);
    tests_run++;
    if ({done, hi, lo} !== {1'b1, 32'h1234, 32'hFFFFFFFF}) begin tests_failed++; $display("FAIL divz_after_start: got %h want %h", {done, hi, lo}, {1'b1, 32'h1234, 32'hFFFFFFFF}); end
    g_hi = 32'h1234; g_lo = 32'hFFFFFFFF;
  endtask

  task automatic test_rst_mid;
    logic [63:0] res;
    int          lat;
    logic        b1;
    start = 1'b1; op = ALU_MULT; sign = 1'b1; src_a = $urandom; src_b = $urandom;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({busy, done, hi, lo} !== 66'd0) begin tests_failed++; $display("FAIL rst_mid_outputs: got %h want 0", {busy, done, hi, lo}); end
    run_op(1'b0, 1'b0, 32'd2, 32'd3, res, lat, b1);
    tests_run++;
    if (res !== 64'd6) begin tests_failed++; $display("FAIL rst_then_multu: got %h want 6", res); end
    tests_run++;
    if (lat !== MUL_LAT) begin tests_failed++; $display("FAIL rst_then_multu_latency: got %0d want %0d", lat, MUL_LAT); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_cancel;
    test_mt;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
